// File: rtl/ascon_p12_engine.sv
// Iterative Ascon permutation core: 12, 8 or 6 rounds, UNROLL rounds per clock.
// Loads x*_i on an accepted start and returns the permuted state with a one-cycle done pulse.
module ascon_p12_engine #(
  parameter int UNROLL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [3:0]  rounds_i,
  input  logic [63:0] x0_i,
  input  logic [63:0] x1_i,
  input  logic [63:0] x2_i,
  input  logic [63:0] x3_i,
  input  logic [63:0] x4_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [63:0] x0_o,
  output logic [63:0] x1_o,
  output logic [63:0] x2_o,
  output logic [63:0] x3_o,
  output logic [63:0] x4_o
);

  typedef logic [4:0][63:0] state_t;
  typedef enum logic {IDLE, RUN} fsm_t;

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // One full Ascon round: constant addition, bitsliced S-box, linear diffusion.
  function automatic state_t ascon_round(input state_t s, input logic [3:0] idx);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [7:0]  c;
    state_t      o;
    c  = 8'hF0 - 8'h0F * {4'd0, idx};
    x0 = s[0];
    x1 = s[1];
    x2 = s[2] ^ {56'd0, c};
    x3 = s[3];
    x4 = s[4];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    o[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    o[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    o[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    o[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    o[4] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return o;
  endfunction

  fsm_t       state, state_n;
  logic [3:0] r, r_n;
  state_t     work, work_n;
  state_t     res, res_n;
  state_t     perm;
  logic       done_n, err_n;
  logic       legal;

  assign legal = (rounds_i == 4'd12) || (rounds_i == 4'd8) || (rounds_i == 4'd6);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    r_n     = r;
    work_n  = work;
    res_n   = res;
    done_n  = 1'b0;
    err_n   = 1'b0;
    // NOTE: blocking assignments here chain the unrolled rounds within one cycle; registers below use non-blocking.
    perm = work;
    for (int u = 0; u < UNROLL; u++) begin
      perm = ascon_round(perm, r + 4'(u));
    end
    case (state)
      IDLE: begin
        if (start_i) begin
          if (legal) begin
            work_n  = {x4_i, x3_i, x2_i, x1_i, x0_i};
            r_n     = 4'd12 - rounds_i;
            state_n = RUN;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      RUN: begin
        work_n = perm;
        r_n    = r + 4'(UNROLL);
        if (r_n == 4'd12) begin
          res_n   = perm;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: the working state is reset along with control so an abort mid-run leaves no stale data behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      r      <= 4'd0;
      work   <= '0;
      res    <= '0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      state  <= state_n;
      r      <= r_n;
      work   <= work_n;
      res    <= res_n;
      done_o <= done_n;
      err_o  <= err_n;
    end
  end

  assign busy_o = (state == RUN);
  assign x0_o   = res[0];
  assign x1_o   = res[1];
  assign x2_o   = res[2];
  assign x3_o   = res[3];
  assign x4_o   = res[4];

endmodule

// File: tb/tb_ascon_p12_engine.sv
// Directed/randomized bench for ascon_p12_engine, one instance per UNROLL setting,
// checked against a table-driven Ascon model with immediate assertions.
module tb_ascon_p12_engine;

  localparam int MAXW = 200;
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0, start2 = 1'b0;
  logic [3:0] rounds = 4'd0;
  logic [4:0][63:0] xin = '0;
  wire  [4:0][63:0] o1, o2;
  wire  busy1, done1, err1, busy2, done2, err2;
  int   sel = 1;
  int   n_checks = 0, n_pass = 0;

  always #5 clk = ~clk;

  ascon_p12_engine #(.UNROLL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .rounds_i(rounds),
    .x0_i(xin[0]), .x1_i(xin[1]), .x2_i(xin[2]), .x3_i(xin[3]), .x4_i(xin[4]),
    .busy_o(busy1), .done_o(done1), .err_o(err1),
    .x0_o(o1[0]), .x1_o(o1[1]), .x2_o(o1[2]), .x3_o(o1[3]), .x4_o(o1[4]));

  ascon_p12_engine #(.UNROLL(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start2), .rounds_i(rounds),
    .x0_i(xin[0]), .x1_i(xin[1]), .x2_i(xin[2]), .x3_i(xin[3]), .x4_i(xin[4]),
    .busy_o(busy2), .done_o(done2), .err_o(err2),
    .x0_o(o2[0]), .x1_o(o2[1]), .x2_o(o2[2]), .x3_o(o2[3]), .x4_o(o2[4]));

  wire busy_s = (sel == 2) ? busy2 : busy1;
  wire done_s = (sel == 2) ? done2 : done1;
  wire [4:0][63:0] out_s = (sel == 2) ? o2 : o1;

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Column-wise S-box lookup over the 64 bit positions, then linear diffusion.
  function automatic logic [4:0][63:0] model_perm(input logic [4:0][63:0] s_in, input int nr);
    logic [4:0][63:0] s, t;
    logic [4:0] v, o;
    s = s_in;
    t = '0;
    for (int i = 12 - nr; i < 12; i++) begin
      s[2] = s[2] ^ 64'((240 - 15 * i) & 255);
      for (int b = 0; b < 64; b++) begin
        v = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
        o = SBOX[v];
        for (int w = 0; w < 5; w++) t[w][b] = o[4 - w];
      end
      for (int w = 0; w < 5; w++) s[w] = t[w] ^ ror(t[w], ROT_A[w]) ^ ror(t[w], ROT_B[w]);
    end
    return s;
  endfunction

  function automatic logic [4:0][63:0] rand_state();
    logic [4:0][63:0] s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_state(input string tag, input logic [4:0][63:0] exp);
    for (int w = 0; w < 5; w++) chk($sformatf("%s_x%0d", tag, w), out_s[w], exp[w]);
  endtask

  // Pulses start on the selected instance; returns at the negedge after the accepting edge.
  task automatic launch(input int u, input logic [3:0] nr, input logic [4:0][63:0] s);
    @(negedge clk);
    sel = u;
    rounds = nr;
    xin = s;
    if (u == 2) start2 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Counts edges after the accepting edge until done is seen, bounded by MAXW.
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0;
    bcnt = busy_s ? 1 : 0;
    while (!done_s && lat < MAXW) begin
      @(negedge clk);
      lat++;
      if (busy_s) bcnt++;
    end
  endtask

  task automatic run_check(input string tag, input int u, input int nr, input logic [4:0][63:0] s);
    int lat, bcnt;
    launch(u, 4'(nr), s);
    wait_done(lat, bcnt);
    chk({tag, "_latency"}, 64'(lat), 64'(nr / u));
    chk({tag, "_busy_cycles"}, 64'(bcnt), 64'(nr / u));
    chk_state(tag, model_perm(s, nr));
  endtask

  initial begin
    logic [4:0][63:0] iv, iv_res, a, b, prev;
    logic [3:0] bad [3];
    int lat, bcnt, dones;

    iv     = '0;
    iv[0]  = 64'h00400C0000000100;
    iv_res = {64'h348FA5C9D525E140, 64'h43189921B8F8E3E8, 64'hB48A92DB98D5DA62,
              64'h8BB21831C60F1002, 64'hEE9398AADB67F03D};

    // Reset state
    #12;
    chk("rst_busy1", 64'(busy1), 64'd0);
    chk("rst_done1", 64'(done1), 64'd0);
    chk("rst_err1", 64'(err1), 64'd0);
    chk("rst_busy2", 64'(busy2), 64'd0);
    sel = 1;
    chk_state("rst_out1", '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ascon-Hash IV, both unroll settings, against the published vector
    launch(1, 4'd12, iv);
    wait_done(lat, bcnt);
    chk("iv_u1_latency", 64'(lat), 64'd12);
    chk("iv_u1_busy_cycles", 64'(bcnt), 64'd12);
    chk_state("iv_u1", iv_res);
    @(negedge clk);
    chk("iv_u1_done_pulse", 64'(done1), 64'd0);

    launch(2, 4'd12, iv);
    wait_done(lat, bcnt);
    chk("iv_u2_latency", 64'(lat), 64'd6);
    chk("iv_u2_busy_cycles", 64'(bcnt), 64'd6);
    chk_state("iv_u2", iv_res);

    // Random states, all round counts
    run_check("r8_u1", 1, 8, rand_state());
    run_check("r6_u1", 1, 6, rand_state());
    run_check("r12_u1", 1, 12, rand_state());
    run_check("r8_u2", 2, 8, rand_state());
    run_check("r6_u2", 2, 6, rand_state());
    a = rand_state();
    run_check("r12_u2", 2, 12, a);

    // Illegal round counts are rejected
    a = rand_state();
    run_check("pre_illegal", 1, 12, a);
    prev = model_perm(a, 12);
    bad[0] = 4'd0;
    bad[1] = 4'd7;
    bad[2] = 4'd15;
    for (int k = 0; k < 3; k++) begin
      launch(1, bad[k], rand_state());
      chk($sformatf("illegal%0d_err", bad[k]), 64'(err1), 64'd1);
      chk($sformatf("illegal%0d_busy", bad[k]), 64'(busy1), 64'd0);
      @(negedge clk);
      chk($sformatf("illegal%0d_err_end", bad[k]), 64'(err1), 64'd0);
      chk($sformatf("illegal%0d_busy_after", bad[k]), 64'(busy1), 64'd0);
      chk_state($sformatf("illegal%0d_hold", bad[k]), prev);
    end

    // start held through RUN, then a back-to-back start in the done cycle
    a = rand_state();
    b = rand_state();
    @(negedge clk);
    sel = 1;
    xin = a;
    rounds = 4'd6;
    start1 = 1'b1;
    @(negedge clk);
    wait_done(lat, bcnt);
    chk("held_latency", 64'(lat), 64'd6);
    chk_state("held", model_perm(a, 6));
    xin = b;
    rounds = 4'd8;
    @(negedge clk);
    chk("b2b_no_gap_busy", 64'(busy1), 64'd1);
    chk("b2b_done_low", 64'(done1), 64'd0);
    start1 = 1'b0;
    wait_done(lat, bcnt);
    chk("b2b_latency", 64'(lat), 64'd8);
    chk_state("b2b", model_perm(b, 8));
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done1) dones++;
    end
    chk("b2b_extra_dones", 64'(dones), 64'd0);

    // Asynchronous reset mid-run, then a clean restart
    launch(1, 4'd12, iv);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy1), 64'd0);
    chk("abort_done", 64'(done1), 64'd0);
    chk_state("abort_out", '0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done1) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    launch(1, 4'd12, iv);
    wait_done(lat, bcnt);
    chk("restart_latency", 64'(lat), 64'd12);
    chk_state("restart", iv_res);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
